// File: rtl/vga_pkg.sv
// vga_pkg: raster timing constants, tile-map geometry and block ids shared
// between the scan generator and the display controller.
package vga_pkg;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_SYNC      = 96;
  localparam int V_SYNC      = 2;
  localparam int H_ACT_START = 144;
  localparam int V_ACT_START = 35;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int TICK_DIV    = 4;

  localparam int TILE_SIZE   = 32;
  localparam int TILE_SHIFT  = 5;
  localparam int MAP_COLS    = 20;
  localparam int MAP_ROWS    = 15;
  localparam int MAP_DEPTH   = MAP_COLS * MAP_ROWS;

  typedef enum logic [2:0] {
    EMPTY      = 3'd0,
    FOREGROUND = 3'd1,
    HALF_SLAB  = 3'd2
  } block_e;

  // Linear tile index for a (row, col) pair: row*20 + col.
  function automatic logic [8:0] tile_addr(input logic [3:0] row, input logic [4:0] col);
    return 9'(row) * 9'(MAP_COLS) + 9'(col);
  endfunction

endpackage

// File: rtl/vga_scan_generator_if.sv
// vga_scan_generator_if: pixel-side interface between the scan generator
// (master) and the display controller (slave).
interface vga_scan_generator_if;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frameStart;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic [2:0] blockType;

  modport master (output hSync, vSync, bright, frameStart, hCount, vCount, blockType);
  modport slave  (input  hSync, vSync, bright, frameStart, hCount, vCount, blockType);
endinterface

// File: rtl/vga_scan_generator_tile_map_ram.sv
// tile_map_ram: 300x3 level tile map, one write port and one enabled read
// port. Reads return the value held before a same-edge write (read-first).
module tile_map_ram
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en_i,
  input  logic [8:0] wr_addr_i,
  input  logic [2:0] wr_data_i,
  input  logic       rd_en_i,
  input  logic [8:0] rd_addr_i,
  output logic [2:0] rd_data_o
);

  logic [2:0] mem_q [0:MAP_DEPTH-1];
  logic [2:0] rd_data_q;

  // Tile write; indices past the end of the map are dropped
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_addr_i < 9'(MAP_DEPTH))) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; non-blocking update gives read-first on collisions
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: pixel tick, h/v scan counters, sync/active flags,
// frame strobe and tile-map lookup, all updated on the same clk edge.
module vga_scan_generator #(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int H_ACT_START = vga_pkg::H_ACT_START,
  parameter int V_ACT_START = vga_pkg::V_ACT_START,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int TICK_DIV    = vga_pkg::TICK_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wrEn,
  input  logic [8:0]                  wrAddr,
  input  logic [2:0]                  wrData,
  vga_scan_generator_if.master        pix
);
  import vga_pkg::*;

  logic [1:0] div_q, div_d;
  logic       tick_s;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       br_q, br_d;
  logic       fs_q, fs_d;
  logic [4:0] col_s;
  logic [3:0] row_s;
  logic [8:0] rd_addr_s;
  logic [2:0] rd_data_s;

  assign tick_s = (div_q == 2'(TICK_DIV - 1));

  // Next-state scan position and everything derived from it
  always_comb begin
    div_d = div_q + 2'd1;
    h_d   = h_q;
    v_d   = v_q;
    fs_d  = 1'b0;
    if (tick_s) begin
      div_d = 2'd0;
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = 10'd0;
        if (v_q == 10'(V_TOTAL - 1)) begin
          v_d  = 10'd0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      div_d = div_q + 2'd1;
    end

    hs_d = (h_d >= 10'(H_SYNC));
    vs_d = (v_d >= 10'(V_SYNC));
    br_d = (h_d >= 10'(H_ACT_START)) && (h_d < 10'(H_ACT_START + H_ACTIVE)) &&
           (v_d >= 10'(V_ACT_START)) && (v_d < 10'(V_ACT_START + V_ACTIVE));

    col_s = 5'((h_d - 10'(H_ACT_START)) >> TILE_SHIFT);
    row_s = 4'((v_d - 10'(V_ACT_START)) >> TILE_SHIFT);
    // Outside the window the column/row arithmetic underflows; park on tile 0
    if (br_d) begin
      rd_addr_s = tile_addr(row_s, col_s);
    end else begin
      rd_addr_s = 9'd0;
    end
  end

  // Scan state registers; reset restarts at (0,0) with no frame strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 2'd0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      br_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      br_q  <= br_d;
      fs_q  <= fs_d;
    end
  end

  // Read on the tick so the tile id lands on the same edge as the counts
  tile_map_ram u_tile_map_ram (
    .clk       (clk),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (wrData),
    .rd_en_i   (tick_s),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  assign pix.hCount     = h_q;
  assign pix.vCount     = v_q;
  assign pix.hSync      = hs_q;
  assign pix.vSync      = vs_q;
  assign pix.bright     = br_q;
  assign pix.frameStart = fs_q;
  // RAM output is not reset, so gate it with the registered active flag
  assign pix.blockType  = br_q ? rd_data_s : EMPTY;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: scoreboard bench. Instance A uses full VGA timing;
// instance B uses a shrunken raster (100x44 counts, 64x40 active window at
// (20,2)) so whole frames, tile lookups and wraps fit in a short run.
// Expected vectors are keyed by (reset segment, rising edges since release).
module tb_vga_scan_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic       we_a = 1'b0, we_b = 1'b0;
  logic [8:0] wa_a = 9'd0, wa_b = 9'd0;
  logic [2:0] wd_a = 3'd0, wd_b = 3'd0;

  vga_scan_generator_if pa ();
  vga_scan_generator_if pb ();

  vga_scan_generator dut_a (
    .clk(clk), .rst_n(rst_a), .wrEn(we_a), .wrAddr(wa_a), .wrData(wd_a), .pix(pa)
  );

  vga_scan_generator #(
    .H_TOTAL(100), .V_TOTAL(44), .H_SYNC(8), .V_SYNC(1),
    .H_ACT_START(20), .V_ACT_START(2), .H_ACTIVE(64), .V_ACTIVE(40)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .wrEn(we_b), .wrAddr(wa_b), .wrData(wd_b), .pix(pb)
  );

  // {h[26:17], v[16:7], hs[6], vs[5], br[4], fs[3], bt[2:0]}
  logic [26:0] obs_a, obs_b;
  assign obs_a = {pa.hCount, pa.vCount, pa.hSync, pa.vSync, pa.bright, pa.frameStart, pa.blockType};
  assign obs_b = {pb.hCount, pb.vCount, pb.hSync, pb.vSync, pb.bright, pb.frameStart, pb.blockType};

  typedef struct {
    int          seg;
    int          cyc;
    logic [26:0] exp;
    string       name;
  } vec_t;

  vec_t  q [2][$];
  int    compared = 0;
  int    mismatched = 0;
  bit    in_rst [2] = '{1'b1, 1'b1};
  int    cyc_c [2] = '{0, 0};
  int    seg_c [2] = '{0, 0};

  task automatic push(input int k, input int s, input int c, input int h, input int v,
                      input bit hs, input bit vs, input bit br, input bit fs,
                      input int bt, input string n);
    vec_t e;
    e.seg  = s;
    e.cyc  = c;
    e.exp  = {10'(h), 10'(v), hs, vs, br, fs, 3'(bt)};
    e.name = n;
    q[k].push_back(e);
  endtask

  task automatic cmp(input string n, input logic [26:0] got, input logic [26:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b br=%b fs=%b bt=%0d, want h=%0d v=%0d hs=%b vs=%b br=%b fs=%b bt=%0d",
               n, got[26:17], got[16:7], got[6], got[5], got[4], got[3], got[2:0],
               exp[26:17], exp[16:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic mon(input int k, input logic rst, input logic [26:0] obs, input int frame);
    vec_t e;
    bit   exp_fs;
    if (!rst) begin
      in_rst[k] = 1'b1;
      cmp((k == 0) ? "a_in_reset" : "b_in_reset", obs, 27'd0);
    end else begin
      if (in_rst[k]) begin
        in_rst[k] = 1'b0;
        seg_c[k]++;
        cyc_c[k] = 0;
      end else begin
        cyc_c[k]++;
      end
      exp_fs = (cyc_c[k] != 0) && ((cyc_c[k] % frame) == 0);
      compared++;
      if (obs[3] !== exp_fs) begin
        mismatched++;
        $display("FAIL %s_frameStart seg %0d cyc %0d: got %b want %b",
                 (k == 0) ? "a" : "b", seg_c[k], cyc_c[k], obs[3], exp_fs);
      end
      while (q[k].size() > 0 &&
             (q[k][0].seg < seg_c[k] || (q[k][0].seg == seg_c[k] && q[k][0].cyc <= cyc_c[k]))) begin
        e = q[k].pop_front();
        if (e.seg == seg_c[k] && e.cyc == cyc_c[k]) begin
          cmp(e.name, obs, e.exp);
        end else begin
          compared++;
          mismatched++;
          $display("FAIL %s: vector seg %0d cyc %0d never sampled", e.name, e.seg, e.cyc);
        end
      end
    end
  endtask

  // Monitor: samples both DUTs on the falling edge, away from the active edge
  always @(negedge clk) begin
    mon(0, rst_a, obs_a, 1680000);
    mon(1, rst_b, obs_b, 17600);
  end

  task automatic wr_b(input int a, input int d);
    @(posedge clk);
    #1 we_b = 1'b1; wa_b = 9'(a); wd_b = 3'(d);
    @(posedge clk);
    #1 we_b = 1'b0;
  endtask

  initial begin
    // Instance A, full timing: cycle = 4*(v*800+h)
    //      k  s  cyc    h    v   hs vs br fs bt
    push(0, 1, 0,     0,   0,  0, 0, 0, 0, 0, "a_release");
    push(0, 1, 3,     0,   0,  0, 0, 0, 0, 0, "a_hold_px0");
    push(0, 1, 4,     1,   0,  0, 0, 0, 0, 0, "a_first_tick");
    push(0, 1, 7,     1,   0,  0, 0, 0, 0, 0, "a_hold_px1");
    push(0, 1, 8,     2,   0,  0, 0, 0, 0, 0, "a_second_tick");
    push(0, 1, 380,   95,  0,  0, 0, 0, 0, 0, "a_hsync_95");
    push(0, 1, 384,   96,  0,  1, 0, 0, 0, 0, "a_hsync_96");
    push(0, 1, 3200,  0,   1,  0, 0, 0, 0, 0, "a_vsync_line1");
    push(0, 1, 6400,  0,   2,  0, 1, 0, 0, 0, "a_vsync_line2");
    push(0, 1, 35196, 799, 10, 1, 1, 0, 0, 0, "a_line_end");
    push(0, 1, 35200, 0,   11, 0, 1, 0, 0, 0, "a_line_wrap");

    // Instance B, small raster: cycle = 4*(v*100+h); tiles 0=1, 1=4, 20=1, 21=2
    push(1, 1, 0,     0,  0,  0, 0, 0, 0, 0, "b_release");
    push(1, 1, 32,    8,  0,  1, 0, 0, 0, 0, "b_hsync_edge");
    push(1, 1, 400,   0,  1,  0, 1, 0, 0, 0, "b_vsync_edge");
    push(1, 1, 840,   10, 2,  1, 1, 0, 0, 0, "b_left_of_window");
    push(1, 1, 876,   19, 2,  1, 1, 0, 0, 0, "b_before_h_start");
    push(1, 1, 880,   20, 2,  1, 1, 1, 0, 1, "b_top_left_tile0");
    push(1, 1, 1004,  51, 2,  1, 1, 1, 0, 1, "b_tile0_last_col");
    push(1, 1, 1008,  52, 2,  1, 1, 1, 0, 4, "b_tile1_first_col");
    push(1, 1, 13804, 51, 34, 1, 1, 1, 0, 1, "b_tile20");
    push(1, 1, 13808, 52, 34, 1, 1, 1, 0, 2, "b_collision_old");
    push(1, 1, 13812, 53, 34, 1, 1, 1, 0, 1, "b_collision_new");
    push(1, 1, 16732, 83, 41, 1, 1, 1, 0, 1, "b_bottom_right");
    push(1, 1, 16736, 84, 41, 1, 1, 0, 0, 0, "b_past_h_end");
    push(1, 1, 16880, 20, 42, 1, 1, 0, 0, 0, "b_past_v_end");
    push(1, 1, 17596, 99, 43, 1, 1, 0, 0, 0, "b_frame_last");
    push(1, 1, 17600, 0,  0,  0, 0, 0, 1, 0, "b_frame_wrap");
    push(1, 1, 17601, 0,  0,  0, 0, 0, 0, 0, "b_frame_strobe_end");
    push(1, 1, 17604, 1,  0,  0, 0, 0, 0, 0, "b_next_frame_tick");
    push(1, 2, 0,     0,  0,  0, 0, 0, 0, 0, "b_restart");
    push(1, 2, 880,   20, 2,  1, 1, 1, 0, 1, "b_restart_tile0");
    push(1, 2, 13808, 52, 34, 1, 1, 1, 0, 1, "b_tile21_rewritten");
    push(1, 2, 17600, 0,  0,  0, 0, 0, 1, 0, "b_restart_wrap");

    fork
      begin : seq_a
        repeat (5) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (35210) @(posedge clk);
      end
      begin : seq_b
        repeat (2) @(posedge clk);
        wr_b(21, 2);
        wr_b(0, 1);
        wr_b(20, 1);
        wr_b(1, 4);
        wr_b(300, 7);
        rst_b = 1'b1;
        // Overwrite tile 21 on the edge where the beam reads its first pixel
        repeat (13807) @(posedge clk);
        #1 we_b = 1'b1; wa_b = 9'd21; wd_b = 3'd1;
        @(posedge clk);
        #1 we_b = 1'b0;
        repeat (18000 - 13808) @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (17610) @(posedge clk);
      end
    join

    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      while (q[k].size() > 0) begin
        vec_t e;
        e = q[k].pop_front();
        compared++;
        mismatched++;
        $display("FAIL %s: vector seg %0d cyc %0d not reached", e.name, e.seg, e.cyc);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
